// File: rtl/or1200_fetch_shell.sv
// ---------------------------------------------------------------------------
// or1200_fetch_shell
//
// Reduced OR1200 top-level shell. It keeps the or1200_top port naming so
// system benches connect unchanged, but executes nothing. It fetches words
// sequentially over the Wishbone instruction bus, starting at RESET_VECTOR.
// The last fetched word (IR) and a small SPR set (NPC, PICMR, PICSR, PMR)
// are visible through the debug port. The data bus is an idle master.
//
// Ports:
//   clk_i, rst_i            single clock, asynchronous active-high reset
//   pic_ints_i              level interrupt inputs, masked by PICMR
//   clmode_i                bus clock ratio: 00 = 1:1, 01 = 1:2, 1x = 1:4
//   iwb_*                   instruction Wishbone master (read-only fetches)
//   dwb_*                   data Wishbone master, outputs held at 0
//   dbg_*                   debug SPR access port, stall and breakpoint
//   pm_*                    power-management outputs decoded from PMR
//
// Optional feature (macro OR1200_WB_CAB_EN):
//   Adds iwb_cab_o, which is high during a request whose address follows the
//   previously acked address by 4. Also adds dwb_cab_o, which is tied to 0.
// ---------------------------------------------------------------------------
module or1200_fetch_shell #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] BUSERR_VECTOR = 32'h0000_0200,
    parameter int          PIC_INTS      = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PIC_INTS-1:0] pic_ints_i,
    input  logic [1:0]          clmode_i,

    input  logic [31:0]         iwb_dat_i,
    input  logic                iwb_ack_i,
    input  logic                iwb_err_i,
    input  logic                iwb_rty_i,
    output logic                iwb_cyc_o,
    output logic                iwb_stb_o,
    output logic                iwb_we_o,
    output logic [31:0]         iwb_adr_o,
    output logic [31:0]         iwb_dat_o,
    output logic [3:0]          iwb_sel_o,
`ifdef OR1200_WB_CAB_EN
    output logic                iwb_cab_o,
    output logic                dwb_cab_o,
`endif

    input  logic [31:0]         dwb_dat_i,
    input  logic                dwb_ack_i,
    input  logic                dwb_err_i,
    input  logic                dwb_rty_i,
    output logic                dwb_cyc_o,
    output logic                dwb_stb_o,
    output logic                dwb_we_o,
    output logic [31:0]         dwb_adr_o,
    output logic [31:0]         dwb_dat_o,
    output logic [3:0]          dwb_sel_o,

    input  logic                dbg_stall_i,
    input  logic                dbg_ewt_i,
    input  logic                dbg_stb_i,
    input  logic                dbg_we_i,
    input  logic [31:0]         dbg_adr_i,
    input  logic [31:0]         dbg_dat_i,
    output logic [3:0]          dbg_lss_o,
    output logic [1:0]          dbg_is_o,
    output logic [10:0]         dbg_wp_o,
    output logic                dbg_bp_o,
    output logic [31:0]         dbg_dat_o,
    output logic                dbg_ack_o,

    input  logic                pm_cpustall_i,
    output logic [3:0]          pm_clksd_o,
    output logic                pm_dc_gate_o,
    output logic                pm_ic_gate_o,
    output logic                pm_dmmu_gate_o,
    output logic                pm_immu_gate_o,
    output logic                pm_tt_gate_o,
    output logic                pm_cpu_gate_o,
    output logic                pm_wakeup_o,
    output logic                pm_lvolt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    fetch_state_t          state_q, state_d;
    logic [1:0]            div_cnt_q;
    logic                  tick;
    logic [31:0]           pc_q;
    logic [31:0]           adr_q;
    logic [31:0]           ir_q;
    logic [PIC_INTS-1:0]   picmr_q;
    logic [PIC_INTS-1:0]   picsr;
    logic [6:0]            pmr_q;
    logic                  dbg_ack_q;
    logic [31:0]           dbg_dat_q;
    logic [31:0]           rd_data;
    logic                  dbg_take;
    logic                  wr_npc, wr_picmr, wr_pmr;
    logic                  start_req, rsp_ack, rsp_err;
    logic                  unused_inputs;

    // Inputs the shell has no use for are gathered here.
    assign unused_inputs = ^{dwb_dat_i, dwb_ack_i, dwb_err_i, dwb_rty_i,
                             dbg_ewt_i, dbg_adr_i[31:2]};

    // The tick selects the low divider bits that must be zero for the
    // chosen bus ratio. The counter free-runs, so a ratio change takes
    // effect immediately.
    always_comb begin
        case (clmode_i)
            2'b00:   tick = 1'b1;
            2'b01:   tick = ~div_cnt_q[0];
            default: tick = (div_cnt_q == 2'b00);
        endcase
    end

    // Fetch FSM next-state logic. Stalls only block new requests. A
    // request that is already on the bus runs until a response arrives.
    // Priority is err > ack > rty.
    always_comb begin
        state_d   = state_q;
        start_req = 1'b0;
        rsp_ack   = 1'b0;
        rsp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && !dbg_stall_i && !pm_cpustall_i) begin
                    state_d   = REQ;
                    start_req = 1'b1;
                end
            end
            REQ: begin
                if (iwb_err_i) begin
                    rsp_err = 1'b1;
                    state_d = IDLE;
                end else if (iwb_ack_i) begin
                    rsp_ack = 1'b1;
                    state_d = IDLE;
                end else if (iwb_rty_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Debug access decode. A strobe is taken only while no ack is pending,
    // so each access yields exactly one single-cycle ack.
    assign dbg_take = dbg_stb_i & ~dbg_ack_q;
    assign wr_npc   = dbg_take & dbg_we_i & (dbg_adr_i[1:0] == 2'd0);
    assign wr_picmr = dbg_take & dbg_we_i & (dbg_adr_i[1:0] == 2'd1);
    assign wr_pmr   = dbg_take & dbg_we_i & (dbg_adr_i[1:0] == 2'd3);

    assign picsr = pic_ints_i & picmr_q;

    always_comb begin
        rd_data = 32'h0;
        case (dbg_adr_i[1:0])
            2'd0:    rd_data = pc_q;
            2'd1:    rd_data[PIC_INTS-1:0] = picmr_q;
            2'd2:    rd_data[PIC_INTS-1:0] = picsr;
            default: rd_data[6:0] = pmr_q;
        endcase
    end

    // State, PC, and bus address registers. The address is latched on
    // entry to REQ, so a debug NPC write cannot disturb a request that is
    // in flight. A debug NPC write always wins over the fetch update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            div_cnt_q <= 2'b00;
            pc_q      <= RESET_VECTOR;
            adr_q     <= 32'h0;
            ir_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_q + 2'd1;
            if (start_req)
                adr_q <= pc_q;
            if (rsp_ack)
                ir_q <= iwb_dat_i;
            if (wr_npc)
                pc_q <= dbg_dat_i;
            else if (rsp_err)
                pc_q <= BUSERR_VECTOR;
            else if (rsp_ack)
                pc_q <= pc_q + 32'd4;
        end
    end

    // SPRs and the debug response. Read data is captured at the acking
    // edge from the register values before that edge. A pending wakeup
    // clears the sleep-mode enables (DME/SME), and it takes priority over a
    // coincident PMR write for those two bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            picmr_q   <= '0;
            pmr_q     <= 7'h0;
            dbg_ack_q <= 1'b0;
            dbg_dat_q <= 32'h0;
        end else begin
            dbg_ack_q <= dbg_take;
            dbg_dat_q <= dbg_take ? rd_data : 32'h0;
            if (wr_picmr)
                picmr_q <= dbg_dat_i[PIC_INTS-1:0];
            if (wr_pmr)
                pmr_q <= dbg_dat_i[6:0];
            if (pm_wakeup_o)
                pmr_q[5:4] <= 2'b00;
        end
    end

`ifdef OR1200_WB_CAB_EN
    logic [31:0] last_ack_adr_q;
    logic        last_ack_vld_q;

    // The burst hint is based on the last acked address, not the PC,
    // because a bus error or a debug write breaks the sequence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_ack_adr_q <= 32'h0;
            last_ack_vld_q <= 1'b0;
        end else if (rsp_ack) begin
            last_ack_adr_q <= adr_q;
            last_ack_vld_q <= 1'b1;
        end
    end

    assign iwb_cab_o = (state_q == REQ) && last_ack_vld_q &&
                       (adr_q == last_ack_adr_q + 32'd4);
    assign dwb_cab_o = 1'b0;
`endif

    assign iwb_cyc_o = (state_q == REQ);
    assign iwb_stb_o = (state_q == REQ);
    assign iwb_we_o  = 1'b0;
    assign iwb_adr_o = adr_q;
    assign iwb_dat_o = 32'h0;
    assign iwb_sel_o = (state_q == REQ) ? 4'hF : 4'h0;

    assign dwb_cyc_o = 1'b0;
    assign dwb_stb_o = 1'b0;
    assign dwb_we_o  = 1'b0;
    assign dwb_adr_o = 32'h0;
    assign dwb_dat_o = 32'h0;
    assign dwb_sel_o = 4'h0;

    assign dbg_lss_o = 4'h0;
    assign dbg_is_o  = ir_q[31:30];
    assign dbg_wp_o  = 11'h0;
    assign dbg_bp_o  = dbg_stall_i & (state_q == IDLE);
    assign dbg_dat_o = dbg_dat_q;
    assign dbg_ack_o = dbg_ack_q;

    assign pm_wakeup_o    = |picsr;
    assign pm_clksd_o     = pmr_q[3:0];
    assign pm_lvolt_o     = pmr_q[4] | pmr_q[5];
    assign pm_cpu_gate_o  = pmr_q[5] & ~pm_wakeup_o;
    assign pm_dc_gate_o   = (pmr_q[6] & (dbg_stall_i | pm_cpustall_i)) | pm_cpu_gate_o;
    assign pm_ic_gate_o   = pm_dc_gate_o;
    assign pm_dmmu_gate_o = pm_dc_gate_o;
    assign pm_immu_gate_o = pm_dc_gate_o;
    assign pm_tt_gate_o   = pm_dc_gate_o;

endmodule

// File: tb/tb_or1200_fetch_shell.sv
// ---------------------------------------------------------------------------
// tb_or1200_fetch_shell
//
// Scoreboard bench for or1200_fetch_shell. The stimulus process pushes the
// expected address of every instruction-bus request, and the expected read
// data of every debug ack, into queues. A monitor pops from these queues
// when the DUT raises iwb_cyc_o or dbg_ack_o.
// ---------------------------------------------------------------------------
module tb_or1200_fetch_shell;

    typedef struct {
        bit          chk;
        logic [31:0] dat;
    } dbg_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [19:0] pic_ints_i;
    logic [1:0]  clmode_i;
    logic [31:0] iwb_dat_i;
    logic        iwb_ack_i, iwb_err_i, iwb_rty_i;
    logic        iwb_cyc_o, iwb_stb_o, iwb_we_o;
    logic [31:0] iwb_adr_o, iwb_dat_o;
    logic [3:0]  iwb_sel_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i, dwb_err_i, dwb_rty_i;
    logic        dwb_cyc_o, dwb_stb_o, dwb_we_o;
    logic [31:0] dwb_adr_o, dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dbg_stall_i, dbg_ewt_i, dbg_stb_i, dbg_we_i;
    logic [31:0] dbg_adr_i, dbg_dat_i;
    logic [3:0]  dbg_lss_o;
    logic [1:0]  dbg_is_o;
    logic [10:0] dbg_wp_o;
    logic        dbg_bp_o;
    logic [31:0] dbg_dat_o;
    logic        dbg_ack_o;
    logic        pm_cpustall_i;
    logic [3:0]  pm_clksd_o;
    logic        pm_dc_gate_o, pm_ic_gate_o, pm_dmmu_gate_o, pm_immu_gate_o;
    logic        pm_tt_gate_o, pm_cpu_gate_o, pm_wakeup_o, pm_lvolt_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_cnt = 0;
    logic [31:0] exp_req[$];
    dbg_exp_t    exp_dbg[$];
    logic        prev_cyc = 1'b0;
    logic [31:0] pc_model;
    logic [7:0]  pm_vec;

    assign pm_vec = {pm_dc_gate_o, pm_ic_gate_o, pm_dmmu_gate_o, pm_immu_gate_o,
                     pm_tt_gate_o, pm_cpu_gate_o, pm_wakeup_o, pm_lvolt_o};

    or1200_fetch_shell dut (
        .clk_i(clk_i), .rst_i(rst_i), .pic_ints_i(pic_ints_i), .clmode_i(clmode_i),
        .iwb_dat_i(iwb_dat_i), .iwb_ack_i(iwb_ack_i), .iwb_err_i(iwb_err_i),
        .iwb_rty_i(iwb_rty_i), .iwb_cyc_o(iwb_cyc_o), .iwb_stb_o(iwb_stb_o),
        .iwb_we_o(iwb_we_o), .iwb_adr_o(iwb_adr_o), .iwb_dat_o(iwb_dat_o),
        .iwb_sel_o(iwb_sel_o),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i), .dwb_err_i(dwb_err_i),
        .dwb_rty_i(dwb_rty_i), .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o),
        .dwb_we_o(dwb_we_o), .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o),
        .dwb_sel_o(dwb_sel_o),
        .dbg_stall_i(dbg_stall_i), .dbg_ewt_i(dbg_ewt_i), .dbg_stb_i(dbg_stb_i),
        .dbg_we_i(dbg_we_i), .dbg_adr_i(dbg_adr_i), .dbg_dat_i(dbg_dat_i),
        .dbg_lss_o(dbg_lss_o), .dbg_is_o(dbg_is_o), .dbg_wp_o(dbg_wp_o),
        .dbg_bp_o(dbg_bp_o), .dbg_dat_o(dbg_dat_o), .dbg_ack_o(dbg_ack_o),
        .pm_cpustall_i(pm_cpustall_i), .pm_clksd_o(pm_clksd_o),
        .pm_dc_gate_o(pm_dc_gate_o), .pm_ic_gate_o(pm_ic_gate_o),
        .pm_dmmu_gate_o(pm_dmmu_gate_o), .pm_immu_gate_o(pm_immu_gate_o),
        .pm_tt_gate_o(pm_tt_gate_o), .pm_cpu_gate_o(pm_cpu_gate_o),
        .pm_wakeup_o(pm_wakeup_o), .pm_lvolt_o(pm_lvolt_o)
    );

    // 10 ns clock plus a free-running cycle counter for spacing checks.
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // Single comparison point shared by the stimulus and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a rising iwb_cyc_o is a new request, and dbg_ack_o high is a
    // debug response. Each one consumes one scoreboard entry.
    always @(negedge clk_i) begin
        if (iwb_cyc_o && !prev_cyc) begin
            if (exp_req.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_req: got 0x%08h, expected none", iwb_adr_o);
            end else begin
                checkOutput("req_adr", iwb_adr_o, exp_req.pop_front());
                checkOutput("req_ctl", {25'h0, iwb_stb_o, iwb_we_o, iwb_sel_o, 1'b0},
                            {25'h0, 1'b1, 1'b0, 4'hF, 1'b0});
            end
        end
        prev_cyc <= iwb_cyc_o;
        if (dbg_ack_o) begin
            if (exp_dbg.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_dbg_ack: got 0x%08h, expected none", dbg_dat_o);
            end else begin
                dbg_exp_t e;
                e = exp_dbg.pop_front();
                if (e.chk) checkOutput("dbg_rdata", dbg_dat_o, e.dat);
            end
        end
    end

    // Waits (bounded) until a request is on the bus, returning at a negedge.
    task automatic waitReq();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (iwb_cyc_o) return;
        end
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL req_timeout: got no request, expected one within 50 cycles");
    endtask

    // Drives one instruction-bus response (0 = ack, 1 = err, 2 = rty). The
    // call is made at a negedge while a request is up. When delayed is set,
    // the response is driven one cycle later. When stall_after is set,
    // dbg_stall_i is raised together with the response to park the FSM.
    task automatic applyStimulus(input int kind, input logic [31:0] dat,
                                 input bit stall_after, input bit delayed);
        if (delayed) @(negedge clk_i);
        iwb_dat_i = dat;
        iwb_ack_i = (kind == 0);
        iwb_err_i = (kind == 1);
        iwb_rty_i = (kind == 2);
        if (stall_after) dbg_stall_i = 1'b1;
        @(posedge clk_i);
        #1;
        iwb_ack_i = 1'b0;
        iwb_err_i = 1'b0;
        iwb_rty_i = 1'b0;
    endtask

    // One debug access. The expected ack entry is pushed before the access,
    // and write acks are consumed without a data check.
    task automatic dbgAccess(input bit we, input logic [1:0] adr,
                             input logic [31:0] dat, input logic [31:0] exp_rd);
        dbg_exp_t e;
        e.chk = !we;
        e.dat = exp_rd;
        exp_dbg.push_back(e);
        @(posedge clk_i);
        #1;
        dbg_stb_i = 1'b1;
        dbg_we_i  = we;
        dbg_adr_i = {30'h0, adr};
        dbg_dat_i = dat;
        @(posedge clk_i);
        #1;
        dbg_stb_i = 1'b0;
        dbg_we_i  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // Runs four back-to-back fetches at a given bus ratio, then checks the
    // spacing between rising request edges. The first request is left
    // unchecked because its divider phase depends on the earlier history.
    task automatic runSpacing(input logic [1:0] clm, input bit delayed,
                              input int spacing, input string name);
        int rise[4];
        @(posedge clk_i);
        #1;
        clmode_i = clm;
        exp_req.push_back(pc_model);
        dbg_stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitReq();
            rise[k] = cyc_cnt;
            pc_model = pc_model + 32'd4;
            if (k < 3) begin
                exp_req.push_back(pc_model);
                applyStimulus(0, 32'h8000_0000, 1'b0, delayed);
            end else begin
                applyStimulus(0, 32'h8000_0000, 1'b1, delayed);
            end
        end
        checkOutput({name, "_gap1"}, 32'(rise[2] - rise[1]), 32'(spacing));
        checkOutput({name, "_gap2"}, 32'(rise[3] - rise[2]), 32'(spacing));
    endtask

    initial begin
        rst_i = 1'b1;
        pic_ints_i = 20'h0;
        clmode_i = 2'b00;
        iwb_dat_i = 32'h0;
        iwb_ack_i = 1'b0;
        iwb_err_i = 1'b0;
        iwb_rty_i = 1'b0;
        dwb_dat_i = 32'h0;
        dwb_ack_i = 1'b0;
        dwb_err_i = 1'b0;
        dwb_rty_i = 1'b0;
        dbg_stall_i = 1'b0;
        dbg_ewt_i = 1'b0;
        dbg_stb_i = 1'b0;
        dbg_we_i = 1'b0;
        dbg_adr_i = 32'h0;
        dbg_dat_i = 32'h0;
        pm_cpustall_i = 1'b0;

        // Reset state.
        #100;
        checkOutput("rst_cyc_stb", {30'h0, iwb_cyc_o, iwb_stb_o}, 32'h0);
        checkOutput("rst_adr", iwb_adr_o, 32'h0);
        checkOutput("rst_sel", {28'h0, iwb_sel_o}, 32'h0);
        checkOutput("rst_pm", {20'h0, pm_clksd_o, pm_vec}, 32'h0);
        checkOutput("rst_dbg", {14'h0, dbg_ack_o, dbg_bp_o, dbg_is_o, dbg_lss_o, 10'h0},
                    32'h0);
        exp_req.push_back(32'h0000_0100);
        #100;
        rst_i = 1'b0;

        // With no responses, the first request stays asserted.
        repeat (79) @(negedge clk_i);
        checkOutput("hold_cyc_stb", {30'h0, iwb_cyc_o, iwb_stb_o}, 32'h3);
        checkOutput("hold_adr", iwb_adr_o, 32'h0000_0100);
        checkOutput("hold_pm", {20'h0, pm_clksd_o, pm_vec}, 32'h0);
        checkOutput("hold_dbg", {dbg_dat_o[15:0] | dbg_dat_o[31:16], dbg_ack_o,
                    dbg_bp_o, dbg_is_o, dbg_lss_o, dbg_wp_o[7:0] | {5'h0, dbg_wp_o[10:8]}},
                    32'h0);
        checkOutput("hold_dwb", dwb_adr_o | dwb_dat_o |
                    {25'h0, dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_sel_o}, 32'h0);

        // ack -> next sequential address; err -> bus-error vector; rty -> same address.
        waitReq();
        exp_req.push_back(32'h0000_0104);
        applyStimulus(0, 32'hC000_0000, 1'b0, 1'b0);
        waitReq();
        checkOutput("dbg_is_after_ack", {30'h0, dbg_is_o}, 32'h3);
        exp_req.push_back(32'h0000_0200);
        applyStimulus(1, 32'h0, 1'b0, 1'b0);
        waitReq();
        exp_req.push_back(32'h0000_0200);
        applyStimulus(2, 32'h0, 1'b0, 1'b0);
        waitReq();
        applyStimulus(0, 32'h0, 1'b1, 1'b0);
        repeat (3) @(negedge clk_i);
        checkOutput("stall_blocks_req", {31'h0, iwb_cyc_o}, 32'h0);
        checkOutput("stall_bp", {31'h0, dbg_bp_o}, 32'h1);

        // Debug NPC access; fetching resumes from the written address.
        dbgAccess(1'b0, 2'd0, 32'h0, 32'h0000_0204);
        dbgAccess(1'b1, 2'd0, 32'h0000_2000, 32'h0);
        dbgAccess(1'b0, 2'd0, 32'h0, 32'h0000_2000);
        exp_req.push_back(32'h0000_2000);
        dbg_stall_i = 1'b0;
        waitReq();
        applyStimulus(0, 32'h0, 1'b1, 1'b0);
        dbgAccess(1'b0, 2'd0, 32'h0, 32'h0000_2004);

        // PIC mask, sleep mode, and wakeup.
        dbgAccess(1'b1, 2'd1, 32'h0000_0001, 32'h0);
        dbgAccess(1'b0, 2'd1, 32'h0, 32'h0000_0001);
        dbgAccess(1'b1, 2'd3, 32'h0000_0020, 32'h0);
        @(negedge clk_i);
        checkOutput("pm_sleep", {24'h0, pm_vec}, 32'h0000_00FD);
        @(posedge clk_i);
        #1;
        pic_ints_i = 20'h00001;
        @(negedge clk_i);
        checkOutput("pm_wakeup", {24'h0, pm_vec}, 32'h0000_0003);
        dbgAccess(1'b0, 2'd2, 32'h0, 32'h0000_0001);
        pic_ints_i = 20'h0;
        dbgAccess(1'b0, 2'd3, 32'h0, 32'h0000_0000);
        checkOutput("pm_after_wake", {24'h0, pm_vec}, 32'h0);

        // Clock-gate enable with stall, SDF field, and doze low-voltage.
        dbgAccess(1'b1, 2'd3, 32'h0000_0045, 32'h0);
        checkOutput("pm_dcge", {20'h0, pm_clksd_o, pm_vec}, 32'h0000_05F8);
        dbgAccess(1'b1, 2'd3, 32'h0000_0010, 32'h0);
        checkOutput("pm_doze", {20'h0, pm_clksd_o, pm_vec}, 32'h0000_0001);
        dbgAccess(1'b1, 2'd3, 32'h0000_0000, 32'h0);

        // PC wraps from the top of the address space to 0.
        dbgAccess(1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0);
        exp_req.push_back(32'hFFFF_FFFC);
        dbg_stall_i = 1'b0;
        waitReq();
        applyStimulus(0, 32'h0, 1'b1, 1'b0);
        dbgAccess(1'b0, 2'd0, 32'h0, 32'h0000_0000);
        pc_model = 32'h0;

        // Request spacing for each bus ratio.
        runSpacing(2'b01, 1'b0, 2, "clm01_imm");
        runSpacing(2'b10, 1'b0, 4, "clm10_imm");
        runSpacing(2'b00, 1'b1, 3, "clm00_dly");
        runSpacing(2'b01, 1'b1, 4, "clm01_dly");
        checkOutput("pc_after_runs", pc_model, 32'h0000_0040);
        checkOutput("dbg_is_runs", {30'h0, dbg_is_o}, 32'h2);

        // An asynchronous reset in mid-cycle drops the request immediately.
        clmode_i = 2'b00;
        exp_req.push_back(pc_model);
        dbg_stall_i = 1'b0;
        waitReq();
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_cyc", {30'h0, iwb_cyc_o, iwb_stb_o}, 32'h0);
        checkOutput("async_rst_is", {30'h0, dbg_is_o}, 32'h0);
        exp_req.push_back(32'h0000_0100);
        @(negedge clk_i);
        rst_i = 1'b0;
        waitReq();
        repeat (3) @(negedge clk_i);
        checkOutput("leftover_req", 32'(exp_req.size()), 32'h0);
        checkOutput("leftover_dbg", 32'(exp_dbg.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/or1200_fetch_shell.md
Name: or1200_fetch_shell

Overview:
- Reduced OR1200 top-level shell: single-clock Wishbone instruction-fetch engine, debug SPR port, PIC mask/status and power-management outputs.
- Sits where or1200_top sits and keeps its port naming, so system benches connect unchanged.
- Executes nothing; fetches sequentially from the reset vector and exposes each fetched word on the debug port.
- The data bus is an idle master.

Parameters:
- RESET_VECTOR, 32'h0000_0100: first fetch address after reset.
- BUSERR_VECTOR, 32'h0000_0200: fetch address after iwb_err_i.
- PIC_INTS, 20: interrupt input width.

Ports:
- clk_i  in  1: the only clock, used for core and both buses.
- rst_i  in  1: asynchronous, active-high reset.
- pic_ints_i  in  PIC_INTS: level interrupts.
- clmode_i  in  2: bus clock ratio (00 = 1:1, 01 = 1:2, 1x = 1:4).
- iwb_dat_i, iwb_ack_i, iwb_err_i, iwb_rty_i  in  32/1/1/1: instruction bus responses.
- iwb_cyc_o, iwb_stb_o, iwb_we_o  out  1 each.
- iwb_adr_o  out  32.
- iwb_dat_o  out  32.
- iwb_sel_o  out  4.
- dwb_dat_i, dwb_ack_i, dwb_err_i, dwb_rty_i  in  32/1/1/1: ignored.
- dwb_cyc_o, dwb_stb_o, dwb_we_o  out  1 each.
- dwb_adr_o, dwb_dat_o  out  32 each.
- dwb_sel_o  out  4.
- dbg_stall_i, dbg_ewt_i  in  1 each.
- dbg_stb_i, dbg_we_i  in  1 each.
- dbg_adr_i  in  32.
- dbg_dat_i  in  32.
- dbg_lss_o  out  4.
- dbg_is_o  out  2.
- dbg_wp_o  out  11.
- dbg_bp_o  out  1.
- dbg_dat_o  out  32.
- dbg_ack_o  out  1.
- pm_cpustall_i  in  1.
- pm_clksd_o  out  4.
- pm_dc_gate_o, pm_ic_gate_o, pm_dmmu_gate_o, pm_immu_gate_o, pm_tt_gate_o, pm_cpu_gate_o, pm_wakeup_o, pm_lvolt_o  out  1 each.

Behaviour:
- Reset values: all outputs 0, PC = RESET_VECTOR, PICMR = 0, PMR = 0, IR = 0, divider counter = 0.
- Ratio tick: a 2-bit divider counter advances every clk_i. A tick occurs when the counter low bits selected by clmode_i are 0: every cycle (00), every 2nd (01), every 4th (1x).
- Fetch FSM states: IDLE, REQ.
  - IDLE -> REQ on a tick when neither dbg_stall_i nor pm_cpustall_i is set. Entering REQ drives cyc=stb=1, adr=PC, sel=4'hF, we=0, iwb_dat_o=0.
  - First request is issued on the first tick after rst_i falls (cycle 0 at 1:1).
- Bus outputs are held constant in REQ until a response arrives. No timeout: with ack/err/rty permanently 0, the request at 0x100 stays asserted indefinitely.
- Responses, sampled in REQ; priority err > ack > rty:
  - ack: IR <= iwb_dat_i, PC <= PC+4 (32-bit wrap 0xFFFFFFFC -> 0), go to IDLE.
  - err: PC <= BUSERR_VECTOR, go to IDLE.
  - rty: PC unchanged, go to IDLE (address is retried).
- A response drops cyc/stb in the same edge, so there is at least one idle cycle between requests.
- Stall inputs never abort an active REQ; they only block new ones.
- Debug register port:
  - dbg_ack_o pulses for 1 cycle on the cycle after dbg_stb_i is sampled high. No new ack while ack is high.
  - Register select is dbg_adr_i[1:0]: 0 = NPC (PC), 1 = PICMR, 2 = PICSR (read-only, = pic_ints_i & PICMR), 3 = PMR (bits [6:0]).
  - Writes take effect at the acking edge.
  - If an NPC write coincides with a fetch ack, the debug write wins. The fetch in flight completes and its IR is kept.
  - dbg_dat_o holds the read data during ack, otherwise 0.
  - dbg_is_o = IR[31:30]; dbg_wp_o = 0; dbg_lss_o = 0.
  - dbg_bp_o = 1 while dbg_stall_i is set and the FSM is in IDLE.
  - dbg_ewt_i is ignored.
- Power management outputs, derived from PMR (SDF = [3:0], DME = [4], SME = [5], DCGE = [6]):
  - pm_wakeup_o = |PICSR (combinational).
  - pm_clksd_o = SDF.
  - pm_lvolt_o = DME | SME.
  - pm_cpu_gate_o = SME & ~pm_wakeup_o.
  - dc/ic/dmmu/immu/tt gates = (DCGE & (dbg_stall_i | pm_cpustall_i)) | pm_cpu_gate_o.
  - Any pm_wakeup_o clears PMR[5:4] on the next edge.
- Data bus outputs are constant 0.
- rst_i asserted mid-cycle drops cyc/stb immediately (asynchronous).

Optional Feature:
- Macro OR1200_WB_CAB_EN.
- Defined: ports iwb_cab_o and dwb_cab_o (out, 1) exist.
  - iwb_cab_o = 1 during a REQ whose address equals the previous acked address + 4; 0 otherwise.
  - dwb_cab_o = 0.
- Undefined: both ports are absent and behaviour is otherwise identical.

Test Plan:
- Hold rst_i 200 ns, release, ack/err/rty tied 0 -> iwb_cyc_o=iwb_stb_o=1 and iwb_adr_o=0x100 from the first cycle, held through 1000 ns. All pm_* and dbg_* outputs 0.
- Ack with iwb_dat_i=0xC000_0000 -> next request at 0x104; dbg_is_o=2'b11.
- Assert err on a request -> next request at 0x200.
- Assert rty on a request -> next request at the same address.
- Debug write NPC=0x2000, then read addr 0 -> one-cycle ack; next fetch at 0x2000; read returns 0x2000 (+4 per ack).
- PICMR=1, pulse pic_ints_i[0] with PMR=0x20 -> pm_cpu_gate_o goes 1->0 and pm_wakeup_o=1; PMR[5:4] cleared.
- clmode_i=01 with ack immediate -> request rising edges spaced 2 cycles apart.
